dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single-ported data memory between the pipeline MEM stage (port 0) and a DMA/debug loader (port 1). Each cycle at most one requester is granted a combinational access to the memory. Read data is registered and returned one cycle later. Port 1 may lock the memory for bounded bursts; otherwise grants alternate round-robin.

## Interface
- `MAX_BURST`, 8: maximum consecutive locked port-1 grants while port 0 is waiting. Legal range 1..255.

- `clk`  in  1  clock; all state updates on posedge
- `rst_n`  in  1  asynchronous, active-low reset
- `p0_req`  in  1  port-0 access request; payload held stable until granted
- `p0_we`  in  1  1 = write, 0 = read
- `p0_addr`  in  32  byte address, passed through unchanged
- `p0_wdata`  in  32  write data
- `p0_gnt`  out  1  combinational; access performed this cycle
- `p0_rdata`  out  32  registered read data
- `p0_rvalid`  out  1  1-cycle pulse; `p0_rdata` is valid
- `p1_req`, `p1_we`, `p1_addr`, `p1_wdata`, `p1_gnt`, `p1_rdata`, `p1_rvalid`  same as port 0, for port 1
- `p1_lock`  in  1  port 1 requests to keep ownership for the next beat
- `mem_read`  out  1  to dmem `memread`
- `mem_write`  out  1  to dmem `memwrite`
- `mem_addr`  out  32  to dmem `addr`
- `mem_wd`  out  32  to dmem `wd`
- `mem_rd`  in  32  from dmem `rd` (combinational read)

## Operation
**State registers**
- `state`: one of S_IDLE, S_P0, S_P1, S_LOCK. Holds the previous cycle's grant. S_LOCK means port 1 was granted with `p1_lock` = 1.
- `last_owner`: 1 bit, the port granted most recently. Retained through idle cycles.
- `burst_cnt`: 8 bits, counts consecutive locked port-1 grants.

**Grant decision (combinational, at most one grant per cycle)**
- Only one port requesting: that port is granted.
- Both requesting, `state` = S_LOCK, `burst_cnt` < MAX_BURST: port 1 is granted.
- Both requesting, `state` = S_LOCK, `burst_cnt` = MAX_BURST: port 0 is granted (forced yield).
- Both requesting otherwise: grant goes to the port that is not `last_owner`.
- Neither requesting: no grant.

**Memory drive**
- Granted port X: `mem_addr` = pX_addr, `mem_wd` = pX_wdata, `mem_write` = pX_we, `mem_read` = !pX_we.
- No grant: all `mem_*` outputs are 0.

**Next state**
- Grant to p0: `state` <= S_P0.
- Grant to p1 with `p1_lock` = 1: `state` <= S_LOCK.
- Grant to p1 with `p1_lock` = 0: `state` <= S_P1.
- No grant: `state` <= S_IDLE.
- `last_owner` updates on any grant.

**Burst counter**
- On a p1 grant with `p1_lock` = 1: `burst_cnt` <= (previous state was S_LOCK ? `burst_cnt` + 1 : 1), saturating at MAX_BURST.
- Any other cycle: `burst_cnt` <= 0.
- Lock ends when `p1_req` drops, when `p1_lock` = 0, or on a forced yield.

**Read return**
- On a granted read, `pX_rdata` <= `mem_rd` at that posedge and `pX_rvalid` = 1 for the following cycle.
- `pX_rdata` holds its value otherwise.
- Writes produce no `rvalid`.

**Addressing**
- No alignment or range checking; dmem word-indexes with addr[9:2].

## Timing
- Grant and memory drive are combinational from `req`, in the same cycle. This gives full throughput: one access per cycle, back-to-back, for a single port.
- Write commits at the posedge that ends the grant cycle. Read data appears in the cycle after the grant, with `rvalid` high in that cycle.
- A read granted one cycle after a write to the same address returns the new data.
- Requester may change its payload or drop `req` in the cycle after `gnt`. `req` held high with an unchanged payload is treated as a new access.
- Reset values:
  - `state` = S_IDLE, `last_owner` = 1 (so port 0 wins the first tie), `burst_cnt` = 0.
  - `p0_rdata` = `p1_rdata` = 0, `p0_rvalid` = `p1_rvalid` = 0.
- Reset asserted mid-burst cancels the lock and any pending `rvalid`. The memory outputs fall to 0 with no grant while `rst_n` is low.

## Test plan
- Port 0 writes 0xDEADBEEF to 0x40, then reads 0x40 -> `p0_gnt` in both cycles; `p0_rvalid` 1 cycle after the read with `p0_rdata` = 0xDEADBEEF.
- Both ports request reads every cycle, no lock -> grants alternate p0, p1, p0, p1…; `mem_read` high every cycle.
- Port 1 locked burst of 12 beats, MAX_BURST = 8, with `p0_req` high throughout -> 8 p1 grants, then 1 p0 grant, then p1 resumes.
- `p1_lock` high but `p1_req` drops for 1 cycle while p0 waits -> p0 granted that cycle; `burst_cnt` = 0 afterwards.
- Same-cycle p0 write of 0x11 and p1 read of 0x80 -> serialized per round-robin; if p1 is granted second it returns 0x11.
- `rst_n` pulsed low during a locked burst -> all `mem_*` = 0, both `rvalid` = 0; first tie after reset goes to p0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Purpose : shares one single-ported data memory between the MEM stage (port 0) and a DMA/debug loader (port 1).
// Latency : grant and memory drive are combinational in the request cycle; read data returns one cycle later.
// Backpres: a requester that is not granted holds req and payload; port 1 may lock for at most MAX_BURST beats.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   pX_req/we/addr/wdata          request, 1 = write, byte address, write data (X = 0, 1)
//   pX_gnt                        combinational grant, access happens this cycle
//   pX_rdata/pX_rvalid            registered read data with a 1-cycle valid pulse
//   p1_lock                       port 1 asks to keep ownership for the next beat
//   mem_read/write/addr/wd/rd     data memory side; all zero when nothing is granted
module dmem_arbiter #(
   parameter int unsigned MAX_BURST = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        p0_req,
   input  logic        p0_we,
   input  logic [31:0] p0_addr,
   input  logic [31:0] p0_wdata,
   output logic        p0_gnt,
   output logic [31:0] p0_rdata,
   output logic        p0_rvalid,
   input  logic        p1_req,
   input  logic        p1_we,
   input  logic [31:0] p1_addr,
   input  logic [31:0] p1_wdata,
   output logic        p1_gnt,
   output logic [31:0] p1_rdata,
   output logic        p1_rvalid,
   input  logic        p1_lock,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd
);

   typedef enum logic [1:0] {S_IDLE, S_P0, S_P1, S_LOCK} state_t;

   localparam logic [7:0] MAX_B = 8'(MAX_BURST);

   state_t      state_q, state_d;
   logic        last_owner_q, last_owner_d;
   logic [7:0]  burst_cnt_q, burst_cnt_d;
   logic [31:0] p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;
   logic        p0_rvalid_q, p0_rvalid_d, p1_rvalid_q, p1_rvalid_d;
   logic        gnt0_raw, gnt1_raw, gnt0, gnt1;

   // Arbitration ignores reset; the state flops are held in reset anyway,
   // and the externally visible grant is masked below.
   always_comb begin
      gnt0_raw = 1'b0;
      gnt1_raw = 1'b0;
      if (p0_req && p1_req) begin
         if (state_q == S_LOCK) begin
            // Locked burst continues until the beat budget is used up.
            if (burst_cnt_q < MAX_B) gnt1_raw = 1'b1;
            else                     gnt0_raw = 1'b1;
         end else if (last_owner_q) begin
            gnt0_raw = 1'b1;
         end else begin
            gnt1_raw = 1'b1;
         end
      end else if (p0_req) begin
         gnt0_raw = 1'b1;
      end else if (p1_req) begin
         gnt1_raw = 1'b1;
      end
   end

   // No memory access may leak out while reset is asserted.
   assign gnt0 = gnt0_raw & rst_n;
   assign gnt1 = gnt1_raw & rst_n;

   always_comb begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_addr  = 32'd0;
      mem_wd    = 32'd0;
      if (gnt0) begin
         mem_read  = ~p0_we;
         mem_write = p0_we;
         mem_addr  = p0_addr;
         mem_wd    = p0_wdata;
      end else if (gnt1) begin
         mem_read  = ~p1_we;
         mem_write = p1_we;
         mem_addr  = p1_addr;
         mem_wd    = p1_wdata;
      end
   end

   always_comb begin
      state_d      = S_IDLE;
      last_owner_d = last_owner_q;
      burst_cnt_d  = 8'd0;
      if (gnt0_raw) begin
         state_d      = S_P0;
         last_owner_d = 1'b0;
      end else if (gnt1_raw) begin
         last_owner_d = 1'b1;
         if (p1_lock) begin
            state_d = S_LOCK;
            if (state_q != S_LOCK)        burst_cnt_d = 8'd1;
            else if (burst_cnt_q >= MAX_B) burst_cnt_d = MAX_B;
            else                           burst_cnt_d = burst_cnt_q + 8'd1;
         end else begin
            state_d = S_P1;
         end
      end
   end

   assign p0_rvalid_d = gnt0_raw & ~p0_we;
   assign p1_rvalid_d = gnt1_raw & ~p1_we;
   assign p0_rdata_d  = p0_rvalid_d ? mem_rd : p0_rdata_q;
   assign p1_rdata_d  = p1_rvalid_d ? mem_rd : p1_rdata_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         last_owner_q <= 1'b1;   // port 0 wins the first tie
         burst_cnt_q  <= 8'd0;
         p0_rdata_q   <= 32'd0;
         p1_rdata_q   <= 32'd0;
         p0_rvalid_q  <= 1'b0;
         p1_rvalid_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_owner_q <= last_owner_d;
         burst_cnt_q  <= burst_cnt_d;
         p0_rdata_q   <= p0_rdata_d;
         p1_rdata_q   <= p1_rdata_d;
         p0_rvalid_q  <= p0_rvalid_d;
         p1_rvalid_q  <= p1_rvalid_d;
      end
   end

   assign p0_gnt    = gnt0;
   assign p1_gnt    = gnt1;
   assign p0_rdata  = p0_rdata_q;
   assign p1_rdata  = p1_rdata_q;
   assign p0_rvalid = p0_rvalid_q;
   assign p1_rvalid = p1_rvalid_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Purpose : directed scoreboard bench for dmem_arbiter with a behavioural word memory behind it.
// Latency : grant expectations are checked in the issue cycle, read data one cycle later.
// Backpres: the stimulus states the hand-computed grant for every driven cycle.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        p0_req, p0_we, p1_req, p1_we, p1_lock;
   logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
   logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
   logic [31:0] p0_rdata, p1_rdata;
   logic        mem_read, mem_write;
   logic [31:0] mem_addr, mem_wd, mem_rd;

   logic [31:0] mem [0:255];

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   typedef struct {
      int          cyc;
      logic [1:0]  g;
      logic        rd;
      logic        wr;
      logic [31:0] a;
      logic [31:0] d;
   } gexp_t;

   typedef struct {
      int          cyc;
      logic        port;
      logic [31:0] d;
   } rexp_t;

   gexp_t gq[$];
   rexp_t rq[$];
   gexp_t mg;
   rexp_t mr;

   dmem_arbiter #(.MAX_BURST(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_gnt(p0_gnt), .p0_rdata(p0_rdata), .p0_rvalid(p0_rvalid),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_gnt(p1_gnt), .p1_rdata(p1_rdata), .p1_rvalid(p1_rvalid),
      .p1_lock(p1_lock),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wd(mem_wd), .mem_rd(mem_rd)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural dmem: combinational read, write at the posedge ending the grant.
   assign mem_rd = mem[mem_addr[9:2]];
   always @(posedge clk) if (mem_write) mem[mem_addr[9:2]] <= mem_wd;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Drive one cycle and push the hand-computed grant and read-return expectations.
   task automatic vec(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                      input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                      input logic lk, input logic e0, input logic e1, input logic [31:0] ed,
                      input bit rd_ok = 1'b1);
      gexp_t g;
      rexp_t r;
      @(posedge clk); #1;
      p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
      p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
      p1_lock = lk;
      g.cyc = cyc;
      g.g   = {e0, e1};
      g.rd  = e0 ? ~w0 : (e1 ? ~w1 : 1'b0);
      g.wr  = e0 ? w0  : (e1 ? w1  : 1'b0);
      g.a   = e0 ? a0  : (e1 ? a1  : 32'd0);
      g.d   = e0 ? d0  : (e1 ? d1  : 32'd0);
      gq.push_back(g);
      if (rd_ok && g.rd) begin
         r.cyc  = cyc + 1;
         r.port = e1;
         r.d    = ed;
         rq.push_back(r);
      end
   endtask

   task automatic idle();
      vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Monitor: read returns first (they belong to the previous cycle), then this cycle's grant.
   always @(negedge clk) begin
      if (rq.size() > 0 && rq[0].cyc < cyc) begin
         mr = rq.pop_front();
         chk("missing_rvalid", 128'(cyc), 128'(mr.cyc));
      end
      if (p0_rvalid || p1_rvalid) begin
         if (rq.size() == 0) begin
            chk("unexpected_rvalid", {p0_rvalid, p1_rvalid}, 2'b00);
         end else begin
            mr = rq.pop_front();
            chk("read_return",
                {32'(cyc), p0_rvalid, p1_rvalid, (p1_rvalid ? p1_rdata : p0_rdata)},
                {32'(mr.cyc), ~mr.port, mr.port, mr.d});
         end
      end
      if (gq.size() > 0 && gq[0].cyc == cyc) begin
         mg = gq.pop_front();
         chk("grant_mem",
             {p0_gnt, p1_gnt, mem_read, mem_write, mem_addr, mem_wd},
             {mg.g, mg.rd, mg.wr, mg.a, mg.d});
      end
   end

   initial begin
      int k;
      logic e1;
      for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + 32'(i);

      // Reset with both ports requesting: nothing may reach the memory.
      rst_n = 1'b0;
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h40; p0_wdata = 32'd0;
      p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h44; p1_wdata = 32'h1234;
      p1_lock = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs",
          {p0_gnt, p1_gnt, mem_read, mem_write, mem_addr, mem_wd, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata},
          128'd0);
      @(posedge clk); #1;
      rst_n = 1'b1; p0_req = 1'b0; p1_req = 1'b0; p1_lock = 1'b0;

      // Port 0 write then read-back of 0x40.
      vec(1, 1, 32'h40, 32'hDEADBEEF, 0, 0, 0, 0, 0, 1, 0, 0);
      vec(1, 0, 32'h40, 0,            0, 0, 0, 0, 0, 1, 0, 32'hDEADBEEF);

      // Both read every cycle: last owner is p0, so p1 goes first, then alternate.
      for (int c = 0; c < 4; c++) begin
         e1 = (c % 2 == 0);
         vec(1, 0, 32'h100, 0, 1, 0, 32'h104, 0, 0, ~e1, e1, e1 ? 32'hA000_0041 : 32'hA000_0040);
      end

      // Locked 12-beat p1 write burst with p0 waiting: 8 p1, 1 forced p0, 4 p1.
      k = 0;
      for (int c = 0; c < 13; c++) begin
         e1 = (c != 8);
         vec(1, 0, 32'h100, 0, 1, 1, 32'h300 + 32'(4 * k), 32'(k), 1,
             ~e1, e1, e1 ? 32'd0 : 32'hA000_0040);
         if (e1) k++;
      end
      vec(1, 0, 32'h100, 0, 0, 0, 0, 0, 0, 1, 0, 32'hA000_0040);

      // Lock held but p1_req drops for one cycle: p0 gets it and the count clears.
      vec(1, 0, 32'h100, 0, 1, 1, 32'h310, 32'h55, 1, 0, 1, 0);
      vec(1, 0, 32'h100, 0, 1, 1, 32'h314, 32'h56, 1, 0, 1, 0);
      vec(1, 0, 32'h100, 0, 0, 1, 32'h318, 32'h57, 1, 1, 0, 32'hA000_0040);
      vec(1, 0, 32'h100, 0, 1, 1, 32'h318, 32'h57, 1, 0, 1, 0);
      chk("burst_cnt_cleared", dut.burst_cnt_q, 8'd0);
      idle();

      // Same-cycle p0 write 0x11 and p1 read of 0x80: p0 first, p1 sees the new data.
      vec(1, 1, 32'h80, 32'h11, 1, 0, 32'h80, 0, 0, 1, 0, 0);
      vec(0, 0, 0, 0,           1, 0, 32'h80, 0, 0, 0, 1, 32'h11);
      idle();

      // Reset pulse during a locked burst.
      vec(0, 0, 0, 0,        1, 0, 32'h84, 0, 1, 0, 1, 32'hA000_0021);
      vec(1, 0, 32'h40, 0,   1, 0, 32'h84, 0, 1, 0, 1, 0, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      mg.cyc = cyc; mg.g = 2'b00; mg.rd = 1'b0; mg.wr = 1'b0; mg.a = 32'd0; mg.d = 32'd0;
      gq.push_back(mg);
      #1;
      chk("reset_mid_burst",
          {p0_rvalid, p1_rvalid, p0_rdata, p1_rdata}, 66'd0);
      @(negedge clk); #1;
      p0_req = 1'b0; p1_req = 1'b0; p1_lock = 1'b0;
      rst_n = 1'b1;
      // First tie after reset goes to p0.
      vec(1, 0, 32'h40, 0, 1, 0, 32'h84, 0, 0, 1, 0, 32'hDEADBEEF);
      idle();
      idle();

      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      chk("leftover_expectations", 128'(gq.size() + rq.size()), 128'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
